// File: rtl/pipe_pkg.sv
// Pipeline-wide constants shared by the MEM/WB register, control unit and writeback register file.
package pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  // Bit positions inside the 2-bit MEM/WB control field
  localparam int unsigned WB_CTRL_WE    = 1;
  localparam int unsigned WB_CTRL_VALID = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_read_port.sv
// One combinational register-file read port: hardwired zero, same-cycle writeback bypass, array.
module wb_read_port #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned ADDR_W = pipe_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  input  logic [DATA_W-1:0] arr_data,
  output logic [DATA_W-1:0] rd_data_c
);
  import pipe_pkg::*;

  always_comb begin
    rd_data_c = arr_data;
    if (addr == ADDR_W'(REG_ZERO)) begin
      rd_data_c = '0;
    end else if (byp_en && (byp_addr == addr)) begin
      rd_data_c = byp_data;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 architectural registers, two ID read ports plus a debug port,
// retired-instruction counter and last-commit trace.
module wb_regfile #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned ADDR_W = pipe_pkg::ADDR_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              r,
  input  logic [1:0]        wb_ctrl,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [ADDR_W-1:0] last_addr,
  output logic [DATA_W-1:0] last_data,
  output logic              commit
);
  import pipe_pkg::*;

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              slot_valid_c;
  logic              commit_c;

  // Reset also gates the commit so the bypass reads zero while r is high
  assign slot_valid_c = wb_ctrl[WB_CTRL_VALID];
  assign commit_c     = wb_ctrl[WB_CTRL_WE] & slot_valid_c &
                        (wb_addr != ADDR_W'(REG_ZERO)) & ~r;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      retire_cnt <= '0;
      last_addr  <= '0;
      last_data  <= '0;
      commit     <= 1'b0;
    end else begin
      commit <= commit_c;
      if (commit_c) begin
        regs[wb_addr] <= wb_data;
        last_addr     <= wb_addr;
        last_data     <= wb_data;
      end
      if (slot_valid_c) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

  wb_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
    .addr      (ra1),
    .byp_en    (commit_c),
    .byp_addr  (wb_addr),
    .byp_data  (wb_data),
    .arr_data  (regs[ra1]),
    .rd_data_c (rd1)
  );

  wb_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
    .addr      (ra2),
    .byp_en    (commit_c),
    .byp_addr  (wb_addr),
    .byp_data  (wb_data),
    .arr_data  (regs[ra2]),
    .rd_data_c (rd2)
  );

  wb_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rpd (
    .addr      (dbg_addr),
    .byp_en    (commit_c),
    .byp_addr  (wb_addr),
    .byp_data  (wb_data),
    .arr_data  (regs[dbg_addr]),
    .rd_data_c (dbg_data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected samples, a negedge monitor compares them.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        r;
  logic [1:0]  wb_ctrl;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic [4:0]  ra1, ra2, dbg_addr;
  logic [31:0] rd1, rd2, dbg_data;
  logic [31:0] retire_cnt;
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  logic        commit;

  logic [31:0] rd1_4, rd2_4, dbg_data_4, last_data_4;
  logic [3:0]  retire_cnt_4;
  logic [4:0]  last_addr_4;
  logic        commit_4;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .r(r), .wb_ctrl(wb_ctrl), .wb_data(wb_data), .wb_addr(wb_addr),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .retire_cnt(retire_cnt), .last_addr(last_addr), .last_data(last_data), .commit(commit)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap case
  wb_regfile #(.CNT_W(4)) u_dut4 (
    .clk(clk), .r(r), .wb_ctrl(wb_ctrl), .wb_data(wb_data), .wb_addr(wb_addr),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_4), .rd2(rd2_4),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_4),
    .retire_cnt(retire_cnt_4), .last_addr(last_addr_4), .last_data(last_data_4), .commit(commit_4)
  );

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } cmt_t;

  chk_t chk_q[$];
  cmt_t cmt_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  localparam int F_RD1 = 0, F_RD2 = 1, F_DBG = 2, F_CNT = 3, F_LADDR = 4,
                 F_LDATA = 5, F_COMMIT = 6, F_CNT4 = 7;

  function automatic logic [31:0] sample(int fld);
    case (fld)
      F_RD1:    return rd1;
      F_RD2:    return rd2;
      F_DBG:    return dbg_data;
      F_CNT:    return retire_cnt;
      F_LADDR:  return {27'b0, last_addr};
      F_LDATA:  return last_data;
      F_COMMIT: return {31'b0, commit};
      F_CNT4:   return {28'b0, retire_cnt_4};
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_now(input string name, input int fld, input logic [31:0] exp);
    chk_t c;
    c.cyc  = cyc;
    c.fld  = fld;
    c.exp  = exp;
    c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic expect_commit(input logic [4:0] addr, input logic [31:0] data);
    cmt_t m;
    m.addr = addr;
    m.data = data;
    cmt_q.push_back(m);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ctrl, input logic [4:0] addr, input logic [31:0] data);
    wb_ctrl = ctrl;
    wb_addr = addr;
    wb_data = data;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: due checks every negedge, trace comparison whenever commit pulses
  initial begin
    chk_t        c;
    cmt_t        m;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
        c   = chk_q.pop_front();
        act = sample(c.fld);
        checks++;
        if (c.cyc != cyc) begin
          errors++;
          $display("FAIL %s: check not sampled in cycle %0d (now %0d)", c.name, c.cyc, cyc);
        end else if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", c.name, act, c.exp, cyc);
        end
      end
      if (commit === 1'b1) begin
        checks++;
        if (cmt_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_commit: last_addr=%0d last_data=0x%08h with none expected",
                   last_addr, last_data);
        end else begin
          m = cmt_q.pop_front();
          if (last_addr !== m.addr || last_data !== m.data) begin
            errors++;
            $display("FAIL commit_trace: got addr=%0d data=0x%08h, expected addr=%0d data=0x%08h",
                     last_addr, last_data, m.addr, m.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    r = 1'b1;
    drive(2'b00, 5'd0, 32'h0);
    ra1 = 5'd0; ra2 = 5'd0; dbg_addr = 5'd0;
    repeat (2) step();

    // Reset state
    ra1 = 5'd7; dbg_addr = 5'd7;
    expect_now("rst_rd1", F_RD1, 32'h0);
    expect_now("rst_dbg", F_DBG, 32'h0);
    expect_now("rst_cnt", F_CNT, 32'h0);
    expect_now("rst_laddr", F_LADDR, 32'h0);
    expect_now("rst_ldata", F_LDATA, 32'h0);
    expect_now("rst_commit", F_COMMIT, 32'h0);
    step();

    // Preload reg 7, then reg 6, then assert reset mid-cycle
    r = 1'b0;
    drive(2'b11, 5'd7, 32'hAAAA_0007);
    expect_commit(5'd7, 32'hAAAA_0007);
    step();
    drive(2'b11, 5'd6, 32'h0000_0066);
    expect_now("pre_rd1", F_RD1, 32'hAAAA_0007);
    expect_now("pre_cnt", F_CNT, 32'd1);
    step();
    r = 1'b1;
    drive(2'b11, 5'd8, 32'h0000_0088);
    ra1 = 5'd7; ra2 = 5'd8; dbg_addr = 5'd6;
    expect_now("async_rd1", F_RD1, 32'h0);
    expect_now("async_rd2_byp", F_RD2, 32'h0);
    expect_now("async_dbg", F_DBG, 32'h0);
    expect_now("async_cnt", F_CNT, 32'h0);
    expect_now("async_laddr", F_LADDR, 32'h0);
    expect_now("async_ldata", F_LDATA, 32'h0);
    expect_now("async_commit", F_COMMIT, 32'h0);
    step();
    r = 1'b0;
    drive(2'b00, 5'd0, 32'h0);
    ra1 = 5'd7; ra2 = 5'd6; dbg_addr = 5'd8;
    expect_now("post_rst_r7", F_RD1, 32'h0);
    expect_now("post_rst_r6", F_RD2, 32'h0);
    expect_now("post_rst_r8", F_DBG, 32'h0);
    expect_now("post_rst_cnt", F_CNT, 32'h0);
    step();

    // Basic write/read
    drive(2'b11, 5'd5, 32'hDEAD_BEEF);
    expect_commit(5'd5, 32'hDEAD_BEEF);
    step();
    drive(2'b00, 5'd0, 32'h0);
    ra1 = 5'd5;
    expect_now("basic_rd1", F_RD1, 32'hDEAD_BEEF);
    expect_now("basic_commit", F_COMMIT, 32'd1);
    expect_now("basic_laddr", F_LADDR, 32'd5);
    expect_now("basic_cnt", F_CNT, 32'd1);
    step();
    expect_now("basic_commit_drop", F_COMMIT, 32'd0);
    expect_now("basic_cnt_hold", F_CNT, 32'd1);

    // Same-cycle bypass on all three ports
    step();
    ra1 = 5'd9; ra2 = 5'd9; dbg_addr = 5'd9;
    drive(2'b11, 5'd9, 32'h1234_5678);
    expect_commit(5'd9, 32'h1234_5678);
    expect_now("byp_rd1", F_RD1, 32'h1234_5678);
    expect_now("byp_rd2", F_RD2, 32'h1234_5678);
    expect_now("byp_dbg", F_DBG, 32'h1234_5678);
    step();
    drive(2'b00, 5'd0, 32'h0);
    expect_now("byp_stored", F_RD2, 32'h1234_5678);
    expect_now("byp_cnt", F_CNT, 32'd2);
    step();

    // Write to $0 is discarded but still retires
    ra1 = 5'd0;
    drive(2'b11, 5'd0, 32'hFFFF_FFFF);
    expect_now("zero_rd1", F_RD1, 32'h0);
    step();
    ra1 = 5'd3;
    drive(2'b10, 5'd3, 32'h3333_3333);
    expect_now("zero_commit", F_COMMIT, 32'd0);
    expect_now("zero_cnt", F_CNT, 32'd3);
    expect_now("bubble_no_byp", F_RD1, 32'h0);
    step();
    drive(2'b00, 5'd0, 32'h0);
    expect_now("bubble_r3", F_RD1, 32'h0);
    expect_now("bubble_cnt", F_CNT, 32'd3);
    expect_now("bubble_commit", F_COMMIT, 32'd0);
    expect_now("bubble_laddr", F_LADDR, 32'd9);
    expect_now("bubble_ldata", F_LDATA, 32'h1234_5678);
    step();

    // Valid slots without RegWrite
    ra1 = 5'd5;
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 5'd5, 32'h5555_5555);
      expect_now("nowr_rd1", F_RD1, 32'hDEAD_BEEF);
      expect_now("nowr_commit", F_COMMIT, 32'd0);
      step();
    end
    drive(2'b00, 5'd0, 32'h0);
    expect_now("nowr_cnt", F_CNT, 32'd7);
    expect_now("nowr_r5", F_RD1, 32'hDEAD_BEEF);
    step();

    // Back-to-back writes to reg 12 tracked through the bypass
    ra1 = 5'd12;
    drive(2'b11, 5'd12, 32'd1);
    expect_commit(5'd12, 32'd1);
    expect_now("b2b_rd1_v1", F_RD1, 32'd1);
    step();
    drive(2'b11, 5'd12, 32'd2);
    expect_commit(5'd12, 32'd2);
    expect_now("b2b_rd1_v2", F_RD1, 32'd2);
    expect_now("b2b_ldata_v1", F_LDATA, 32'd1);
    step();
    drive(2'b11, 5'd12, 32'd3);
    expect_commit(5'd12, 32'd3);
    expect_now("b2b_rd1_v3", F_RD1, 32'd3);
    expect_now("b2b_ldata_v2", F_LDATA, 32'd2);
    step();
    drive(2'b00, 5'd0, 32'h0);
    expect_now("b2b_final", F_RD1, 32'd3);
    expect_now("b2b_laddr", F_LADDR, 32'd12);
    expect_now("b2b_cnt", F_CNT, 32'd10);
    expect_now("b2b_cnt4", F_CNT4, 32'd10);

    // Counter wrap on the 4-bit instance: 16 slots -> 0, 17 -> 1
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 5'd0, 32'h0);
      step();
    end
    expect_now("wrap16_cnt", F_CNT, 32'd16);
    expect_now("wrap16_cnt4", F_CNT4, 32'd0);
    step();
    drive(2'b00, 5'd0, 32'h0);
    expect_now("wrap17_cnt", F_CNT, 32'd17);
    expect_now("wrap17_cnt4", F_CNT4, 32'd1);
    expect_now("wrap_commit", F_COMMIT, 32'd0);
    expect_now("wrap_ldata", F_LDATA, 32'd3);

    repeat (3) step();
    checks++;
    if (chk_q.size() != 0 || cmt_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d checks and %0d commits still pending, expected 0 and 0",
               chk_q.size(), cmt_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
